mmio_slot_master: RTL
=====================

# mmio_slot_master

Bus-side initiator for the MMIO slot interface: accepts single-outstanding read/write requests from the processor-side request port and drives the shared slot bus (per-slot chip selects, read/write strobes, register address, write data) that every slot core responds on. It returns read data from the selected slot's `rd_data` and a completion pulse for every request. It sits between the CPU bus bridge and the array of slot cores (timer, GPIO, UART, ...).

## Interface
- `NUM_SLOTS`, default 64: number of mapped slots, range 1..64. Slot indices ≥ `NUM_SLOTS` are unmapped.
- `clk` in, 1: clock.
- `reset` in, 1: reset; asynchronous, active-high.
- `req_valid` in, 1: request present.
- `req_ready` out, 1: request accepted when `req_valid && req_ready`.
- `req_write` in, 1: 1 = write, 0 = read.
- `req_addr` in, 11: word address; [10:5] slot index, [4:0] slot register.
- `req_wdata` in, 32: write data.
- `rsp_valid` out, 1: one-cycle completion pulse. There is no backpressure on the response side.
- `rsp_rdata` out, 32: read data, valid while `rsp_valid` is high.
- `rsp_err` out, 1: access hit an unmapped slot; valid while `rsp_valid` is high.
- `slot_cs` out, `NUM_SLOTS`: one-hot chip select.
- `slot_read` out, 1: read strobe.
- `slot_write` out, 1: write strobe.
- `slot_addr` out, 5: slot register address.
- `slot_wr_data` out, 32: write data to the slots.
- `slot_rd_data` in, `NUM_SLOTS*32`: concatenated slot read data; slot k occupies [32k+31:32k].

## Operation
- FSM states and transitions:
  - IDLE → ACCESS on accept.
  - ACCESS → RESP unconditionally.
  - RESP → IDLE unconditionally.
- `req_ready` = 1 only in IDLE.
- On accept, the block registers `req_write`, `req_addr` and `req_wdata`, and computes the decoded one-hot chip select.
- In ACCESS, the slot outputs are driven from registers:
  - mapped slot: `slot_cs` has exactly one bit set; `slot_read = !write`; `slot_write = write`.
  - unmapped slot: `slot_cs = 0` and no strobe.
- At the end of ACCESS, the read return register captures `slot_rd_data` of the selected slot for a mapped read, 0 for a mapped write, and the unmapped value (see Configuration) otherwise.
- In RESP, `rsp_valid` = 1. `rsp_rdata` and `rsp_err` hold their values until the next RESP.
- Outside ACCESS, `slot_cs`, `slot_read` and `slot_write` are 0. `slot_addr` and `slot_wr_data` hold the last values.
- A slot's read data is combinational from that slot's registers and is sampled only in ACCESS. The same holds for writes: the write takes effect at the clock edge that ends ACCESS.

## Timing
- Accept at edge N:
  - slot strobes high for exactly the cycle between edges N and N+1;
  - `rsp_valid` high for the cycle between edges N+1 and N+2;
  - `req_ready` high again after edge N+2.
- Maximum throughput is 1 request per 3 cycles. With `req_valid` held high, accepts occur at edges N, N+3, N+6, ...
- Reset values: all outputs 0 except `req_ready`, which is 1. State is IDLE.
- Reset mid-transaction aborts it immediately:
  - strobes drop asynchronously;
  - no `rsp_valid` is issued;
  - a write strobe cut by reset may or may not have taken effect in the slot.
- Request inputs are ignored outside IDLE. Changing `req_*` after accept has no effect.

## Configuration
- `MMIO_UNMAPPED_ERR_EN` defined:
  - unmapped access returns `rsp_err = 1` and `rsp_rdata = 32'hDEAD_BEEF`, for both reads and writes;
  - mapped access returns `rsp_err = 0`.
- Not defined:
  - `rsp_err` is tied to 0;
  - unmapped reads return 32'h0000_0000;
  - unmapped writes complete silently.
- In both modes, no slot strobe is ever generated for an unmapped index, and the timing is identical.

## Structure
- Package `mmio_pkg` holds:
  - `SLOT_IDX_W = 6`, `REG_ADDR_W = 5`, `DATA_W = 32`;
  - `UNMAPPED_RDATA = 32'hDEAD_BEEF`;
  - the state enum `mmio_state_t` {IDLE, ACCESS, RESP}.
- One sub-module, `slot_decoder`: binary slot index → one-hot `NUM_SLOTS` select plus a `mapped` flag. It is purely combinational and instantiated once.
- The read mux uses an indexed part-select on `slot_rd_data` using the registered index.

## Test plan
- Write to slot 2, reg 2, data 32'h1: accept at edge N → in ACCESS, `slot_cs = 1<<2`, `slot_write = 1`, `slot_addr = 2`, `slot_wr_data = 1` → `rsp_valid` at N+1..N+2 with `rsp_rdata = 0`, `rsp_err = 0`.
- Read from slot 2, reg 1, with slot 2 driving 32'h0000_1234 → `slot_read = 1` for one cycle, `rsp_rdata = 32'h1234`, `rsp_err = 0`.
- `NUM_SLOTS = 16`, read from slot 20, macro defined → `slot_cs = 0`, no strobe, `rsp_err = 1`, `rsp_rdata = 32'hDEAD_BEEF`. Macro undefined → `rsp_err = 0`, `rsp_rdata = 0`.
- `req_valid` held high for 10 cycles with alternating write/read to slots 0 and 3 → accepts every 3rd edge, one `rsp_valid` per accept, and `slot_cs` is never multi-hot.
- Assert `reset` during ACCESS of a read → strobes and `slot_cs` go to 0 immediately, no `rsp_valid` follows, `req_ready = 1` after reset release.
- Change `req_addr` and `req_wdata` while in ACCESS → `slot_addr` and `slot_wr_data` keep the values captured at accept.

Source files
------------

// File: rtl/mmio_pkg.sv
// Shared definitions for the MMIO slot bus: field widths, the value returned
// for unmapped slots, and the slot master state encoding.
package mmio_pkg;

    localparam int SLOT_IDX_W = 6;
    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;

    localparam logic [DATA_W-1:0] UNMAPPED_RDATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } mmio_state_t;

endpackage

// File: rtl/slot_decoder.sv
// Binary slot index to one-hot chip select. Indices at or above NUM_SLOTS
// produce an all-zero select and a cleared mapped flag.
module slot_decoder
    import mmio_pkg::*;
#(
    parameter int NUM_SLOTS = 64
) (
    input  logic [SLOT_IDX_W-1:0] slot_idx,
    output logic [NUM_SLOTS-1:0]  slot_sel,
    output logic                  mapped
);

    // An index is mapped only when it names one of the populated slots
    always_comb begin
        mapped = (int'(slot_idx) < NUM_SLOTS);
    end

    // One bit per populated slot; an out-of-range index matches no bit
    always_comb begin
        slot_sel = '0;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            slot_sel[k] = (int'(slot_idx) == k);
        end
    end

endmodule

// File: rtl/mmio_slot_master.sv
// Single-outstanding initiator for the shared MMIO slot bus. Each request is
// captured in IDLE, driven onto the slot bus for one ACCESS cycle, and
// completed with a one-cycle response pulse in RESP.
// Optional build macro: MMIO_UNMAPPED_ERR_EN -- when defined, accesses to
// unmapped slots report rsp_err and return UNMAPPED_RDATA; otherwise they
// complete silently with zero read data.
module mmio_slot_master
    import mmio_pkg::*;
#(
    parameter int NUM_SLOTS = 64
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              req_valid,
    output logic                              req_ready,
    input  logic                              req_write,
    input  logic [SLOT_IDX_W+REG_ADDR_W-1:0]  req_addr,
    input  logic [DATA_W-1:0]                 req_wdata,
    output logic                              rsp_valid,
    output logic [DATA_W-1:0]                 rsp_rdata,
    output logic                              rsp_err,
    output logic [NUM_SLOTS-1:0]              slot_cs,
    output logic                              slot_read,
    output logic                              slot_write,
    output logic [REG_ADDR_W-1:0]             slot_addr,
    output logic [DATA_W-1:0]                 slot_wr_data,
    input  logic [NUM_SLOTS*DATA_W-1:0]       slot_rd_data
);

    mmio_state_t             state;
    logic                    accept;
    logic                    write_q;
    logic [SLOT_IDX_W-1:0]   slot_idx_q;
    logic [NUM_SLOTS-1:0]    cs_q;
    logic                    mapped_q;
    logic [NUM_SLOTS-1:0]    dec_sel;
    logic                    dec_mapped;
    logic [DATA_W-1:0]       ret_data;
    logic                    ret_err;
    logic [DATA_W-1:0]       rdata_q;

    assign accept = req_valid && (state == IDLE);

    slot_decoder #(
        .NUM_SLOTS (NUM_SLOTS)
    ) u_slot_decoder (
        .slot_idx (req_addr[SLOT_IDX_W+REG_ADDR_W-1:REG_ADDR_W]),
        .slot_sel (dec_sel),
        .mapped   (dec_mapped)
    );

    // Three-phase sequence; every request spends exactly one cycle in each state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    state <= accept ? ACCESS : IDLE;
                ACCESS:  state <= RESP;
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Capture the request and its decoded select so later input changes are ignored
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            write_q      <= 1'b0;
            slot_idx_q   <= '0;
            cs_q         <= '0;
            mapped_q     <= 1'b0;
            slot_addr    <= '0;
            slot_wr_data <= '0;
        end else if (accept) begin
            write_q      <= req_write;
            slot_idx_q   <= req_addr[SLOT_IDX_W+REG_ADDR_W-1:REG_ADDR_W];
            cs_q         <= dec_sel;
            mapped_q     <= dec_mapped;
            slot_addr    <= req_addr[REG_ADDR_W-1:0];
            slot_wr_data <= req_wdata;
        end
    end

    // Select the value the response will carry; slot data is only meaningful for mapped reads
    always_comb begin
        ret_data = '0;
        ret_err  = 1'b0;
        if (mapped_q) begin
            if (!write_q) begin
                ret_data = slot_rd_data[{slot_idx_q, 5'd0} +: DATA_W];
            end
        end else begin
`ifdef MMIO_UNMAPPED_ERR_EN
            ret_data = UNMAPPED_RDATA;
            ret_err  = 1'b1;
`else
            ret_data = '0;
            ret_err  = 1'b0;
`endif
        end
    end

    // Sample the return value at the edge that closes ACCESS and hold it until the next one
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_q <= '0;
        end else if (state == ACCESS) begin
            rdata_q <= ret_data;
        end
    end

`ifdef MMIO_UNMAPPED_ERR_EN
    logic err_q;

    // Error flag tracks the captured return value
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (state == ACCESS) begin
            err_q <= ret_err;
        end
    end

    assign rsp_err = err_q;
`else
    logic unused_err;

    assign unused_err = ret_err;
    assign rsp_err    = 1'b0;
`endif

    // Strobes derive from state so a reset removes them without waiting for a clock
    always_comb begin
        slot_cs    = '0;
        slot_read  = 1'b0;
        slot_write = 1'b0;
        if (state == ACCESS) begin
            slot_cs    = cs_q;
            slot_read  = mapped_q && !write_q;
            slot_write = mapped_q && write_q;
        end
    end

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign rsp_rdata = rdata_q;

endmodule
